mux_sel_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 8:1 datapath mux, such as a shared result or operand bus, among 8 requesters. It drives the mux select lines (s2,s1,s0 = sel[2:0]) and a one-hot grant vector. A grant is held until the owner releases it, drops its request, or exceeds a hold limit. It sits between the requesting units and the gate-level 8:1 mux bank in the datapath.

---
 rtl/mux_sel_rr_arbiter_pkg.sv | 9 +
 rtl/mux_sel_rr_arbiter_rr_pick8.sv | 25 ++
 rtl/mux_sel_rr_arbiter.sv | 69 ++++++
 tb/tb_mux_sel_rr_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mux_sel_rr_arbiter_pkg.sv
// mux_sel_rr_arbiter_pkg: shared sizes and FSM encoding for the round-robin mux-select arbiter
package mux_sel_rr_arbiter_pkg;
  localparam int N_REQ = 8;
  localparam int SEL_W = 3;
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;
endpackage

// File: rtl/mux_sel_rr_arbiter_rr_pick8.sv
// rr_pick8: combinational circular priority pick starting at ptr, skipping masked requesters
module rr_pick8
  import mux_sel_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  input  logic [N_REQ-1:0] mask,
  output logic             any,
  output logic [SEL_W-1:0] idx
);
  logic [N_REQ-1:0]   eff;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [SEL_W-1:0]   off;
  always_comb begin
    eff = req & ~mask;
    dbl = {eff, eff};
    rot = dbl[ptr +: N_REQ];
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (rot[i]) off = SEL_W'(i);
    any = |eff;
    idx = ptr + off;
  end
endmodule

// File: rtl/mux_sel_rr_arbiter.sv
// mux_sel_rr_arbiter: round-robin owner of a shared 8:1 mux with release, drop and hold-limit preemption
module mux_sel_rr_arbiter
  import mux_sel_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             rel,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             timeout
);
  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [HW-1:0]    hold_cnt;
  logic             own_req, others, end_to, grant_end, is_to, any;
  logic [SEL_W-1:0] pick_ptr, idx;
  logic [N_REQ-1:0] mask;
  // hold_cnt parks at HOLD_LAST so a late-arriving competitor still preempts
  always_comb begin
    own_req   = req[sel];
    others    = |(req & ~gnt);
    end_to    = state == GRANT && MAX_HOLD != 0 && hold_cnt == HOLD_LAST && others;
    grant_end = state == GRANT && (rel || !own_req || end_to);
    is_to     = end_to && !rel && own_req;
    pick_ptr  = (state == GRANT) ? sel + SEL_W'(1) : ptr;
    mask      = is_to ? gnt : '0;
  end
  rr_pick8 u_pick (
    .req (req),
    .ptr (pick_ptr),
    .mask(mask),
    .any (any),
    .idx (idx)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= '0;
      sel      <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else if (state == IDLE || grant_end) begin
      timeout <= is_to;
      if (state == GRANT) ptr <= pick_ptr;
      if (any) begin
        state    <= GRANT;
        gnt      <= N_REQ'(1) << idx;
        sel      <= idx;
        busy     <= 1'b1;
        hold_cnt <= '0;
      end else begin
        state <= IDLE;
        gnt   <= '0;
        busy  <= 1'b0;
      end
    end else begin
      timeout  <= 1'b0;
      hold_cnt <= (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// tb_mux_sel_rr_arbiter: directed table, hand sequences and random run against a behavioural model
module tb_mux_sel_rr_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req = '0;
  logic       rel = 1'b0;
  logic [7:0] gnt16, gnt4;
  logic [2:0] sel16, sel4;
  logic       busy16, busy4, to16, to4;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mux_sel_rr_arbiter #(.MAX_HOLD(16)) dut (
    .clk(clk), .reset(reset), .req(req), .rel(rel),
    .gnt(gnt16), .sel(sel16), .busy(busy16), .timeout(to16)
  );
  mux_sel_rr_arbiter #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .reset(reset), .req(req), .rel(rel),
    .gnt(gnt4), .sel(sel4), .busy(busy4), .timeout(to4)
  );

  typedef struct {
    bit busy;
    int owner;
    int ptr;
    int cnt;
    bit to;
    int sel;
  } mdl_t;

  typedef struct {
    bit       rs;
    bit [7:0] req;
    bit       rel;
    bit [7:0] gnt;
    bit [2:0] sel;
    bit       busy;
    bit       to;
  } vec_t;

  mdl_t m16 = '{0, 0, 0, 0, 0, 0};
  mdl_t m4  = '{0, 0, 0, 0, 0, 0};
  vec_t vq[$];

  function automatic mdl_t step(mdl_t m, logic [7:0] r, bit rl, bit rs, int mh);
    mdl_t       n;
    bit         arb, pre, found;
    int         p;
    logic [7:0] cand;
    n = m;
    n.to = 0;
    if (rs) return '{0, 0, 0, 0, 0, 0};
    arb = !m.busy;
    p = m.ptr;
    cand = r;
    if (m.busy) begin
      pre = mh != 0 && m.cnt >= mh - 1 && (r & ~(8'd1 << m.owner)) != 0;
      if (rl || !r[m.owner] || pre) begin
        arb = 1;
        p = (m.owner + 1) % 8;
        n.ptr = p;
        if (pre && !rl && r[m.owner]) begin
          n.to = 1;
          cand[m.owner] = 1'b0;
        end
      end else n.cnt = m.cnt + 1;
    end
    if (arb) begin
      found = 0;
      for (int i = 0; i < 8; i++)
        if (!found && cand[(p + i) % 8]) begin
          found = 1;
          n.owner = (p + i) % 8;
          n.sel = n.owner;
          n.cnt = 0;
        end
      n.busy = found;
    end
    return n;
  endfunction

  function automatic logic [7:0] mgnt(mdl_t m);
    return m.busy ? (8'd1 << m.owner) : 8'd0;
  endfunction

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m16 = step(m16, req, rel, reset, 16);
    m4  = step(m4, req, rel, reset, 4);
    #1;
    chk("m16_gnt", gnt16, mgnt(m16));
    chk("m16_sel", 8'(sel16), 8'(m16.sel));
    chk("m16_busy", 8'(busy16), 8'(m16.busy));
    chk("m16_to", 8'(to16), 8'(m16.to));
    chk("m4_gnt", gnt4, mgnt(m4));
    chk("m4_sel", 8'(sel4), 8'(m4.sel));
    chk("m4_busy", 8'(busy4), 8'(m4.busy));
    chk("m4_to", 8'(to4), 8'(m4.to));
  endtask

  task automatic drive(bit rs, logic [7:0] r, bit rl);
    reset = rs;
    req = r;
    rel = rl;
  endtask

  initial begin
    vq.push_back('{1, 8'h00, 0, 8'h00, 3'd0, 0, 0});
    vq.push_back('{0, 8'h04, 0, 8'h04, 3'd2, 1, 0});
    vq.push_back('{0, 8'h04, 0, 8'h04, 3'd2, 1, 0});
    vq.push_back('{0, 8'h00, 1, 8'h00, 3'd2, 0, 0});
    vq.push_back('{1, 8'h00, 0, 8'h00, 3'd0, 0, 0});
    vq.push_back('{0, 8'hFF, 0, 8'h01, 3'd0, 1, 0});
    for (int k = 1; k <= 9; k++)
      vq.push_back('{0, 8'hFF, 1, 8'(1 << (k % 8)), 3'(k % 8), 1, 0});
    vq.push_back('{1, 8'h00, 0, 8'h00, 3'd0, 0, 0});
    vq.push_back('{0, 8'h20, 0, 8'h20, 3'd5, 1, 0});
    vq.push_back('{0, 8'h21, 0, 8'h20, 3'd5, 1, 0});
    vq.push_back('{0, 8'h01, 0, 8'h01, 3'd0, 1, 0});
    vq.push_back('{0, 8'h20, 1, 8'h20, 3'd5, 1, 0});
    vq.push_back('{1, 8'h81, 0, 8'h00, 3'd0, 0, 0});
    vq.push_back('{0, 8'h81, 0, 8'h01, 3'd0, 1, 0});
    foreach (vq[i]) begin
      drive(vq[i].rs, vq[i].req, vq[i].rel);
      tick();
      chk($sformatf("vec%0d_gnt", i), gnt16, vq[i].gnt);
      chk($sformatf("vec%0d_sel", i), 8'(sel16), 8'(vq[i].sel));
      chk($sformatf("vec%0d_busy", i), 8'(busy16), 8'(vq[i].busy));
      chk($sformatf("vec%0d_to", i), 8'(to16), 8'(vq[i].to));
    end
    // owner 3 held for exactly 16 cycles, then preempted in favour of 7
    drive(1, 8'h00, 0);
    tick();
    drive(0, 8'h88, 0);
    for (int c = 0; c < 16; c++) begin
      tick();
      chk($sformatf("hold3_c%0d", c), gnt16, 8'h08);
      chk("hold3_to", 8'(to16), 8'h00);
    end
    tick();
    chk("pre_gnt", gnt16, 8'h80);
    chk("pre_sel", 8'(sel16), 8'd7);
    chk("pre_to", 8'(to16), 8'h01);
    for (int c = 1; c < 15; c++) begin
      tick();
      chk("hold7_gnt", gnt16, 8'h80);
      chk("hold7_to", 8'(to16), 8'h00);
    end
    // release coincides with the hold limit: plain handover, no timeout
    tick();
    chk("hold7_last", gnt16, 8'h80);
    drive(0, 8'h88, 1);
    tick();
    chk("relto_gnt", gnt16, 8'h08);
    chk("relto_sel", 8'(sel16), 8'd3);
    chk("relto_to", 8'(to16), 8'h00);
    // lone requester is never preempted under the short hold limit
    drive(1, 8'h00, 0);
    tick();
    drive(0, 8'h10, 0);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("solo4_gnt", gnt4, 8'h10);
      chk("solo4_to", 8'(to4), 8'h00);
    end
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(5) == 0) req = 8'($urandom);
      rel = $urandom_range(7) == 0;
      reset = $urandom_range(199) == 0;
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
